// File: rtl/bcd.sv
// bcd: single-digit BCD to Excess-3 converter with registered outputs and invalid-code flag
module bcd (
   input  logic clk,
   input  logic rst,
   input  logic p,
   input  logic q,
   input  logic r,
   input  logic s,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic err
);
   logic [3:0] x;
   logic [3:0] y_nxt;
   logic       err_nxt;
   assign x = {p, q, r, s};
   // add 3 to a valid digit; codes above 9 become 0000 with the flag set
   always_comb begin
      err_nxt = x > 4'd9;
      y_nxt   = err_nxt ? 4'd0 : x + 4'd3;
   end
   // capture every edge; reset clears to the "no data" pattern without a clock
   always_ff @(posedge clk or posedge rst)
      if (rst) {a, b, c, d, err} <= '0;
      else     {a, b, c, d, err} <= {y_nxt, err_nxt};
endmodule

// File: tb/tb_bcd.sv
`timescale 1ns/1ps
// tb_bcd: scoreboard bench for the BCD to Excess-3 converter
module tb_bcd;
   logic clk = 1'b0;
   logic rst;
   logic p, q, r, s;
   logic a, b, c, d, err;
   int errors = 0;
   int checks = 0;
   logic [4:0] sb[$];
   logic [4:0] exp_tab [16] = '{
      5'b0011_0, 5'b0100_0, 5'b0101_0, 5'b0110_0, 5'b0111_0,
      5'b1000_0, 5'b1001_0, 5'b1010_0, 5'b1011_0, 5'b1100_0,
      5'b0000_1, 5'b0000_1, 5'b0000_1, 5'b0000_1, 5'b0000_1, 5'b0000_1};

   bcd dut (.clk(clk), .rst(rst), .p(p), .q(q), .r(r), .s(s),
            .a(a), .b(b), .c(c), .d(d), .err(err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got y=%b err=%b, want y=%b err=%b at %0t",
                  name, act[4:1], act[0], exp[4:1], exp[0], $time);
      end
   endtask

   task automatic drive(input logic [3:0] x);
      @(negedge clk);
      {p, q, r, s} = x;
      sb.push_back(exp_tab[x]);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) chk("scoreboard", {a, b, c, d, err}, sb.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      {p, q, r, s} = 4'b1001;
      #1;
      chk("reset_immediate", {a, b, c, d, err}, 5'b0000_0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("reset_hold", {a, b, c, d, err}, 5'b0000_0);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(exp_tab[9]);
      for (int i = 0; i < 16; i++) drive(4'(i));
      drive(4'b0100);
      @(posedge clk);
      #3;
      {p, q, r, s} = 4'b0111;
      sb.push_back(exp_tab[7]);
      #1;
      chk("latency_hold", {a, b, c, d, err}, 5'b0111_0);
      @(posedge clk);
      drive(4'b1001);
      drive(4'b1010);
      drive(4'b1001);
      drive(4'b1000);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset", {a, b, c, d, err}, 5'b0000_0);
      rst = 1'b0;
      drive(4'b0010);
      for (int k = 0; k < 100; k++)
         drive({1'((k / 5) % 2), 1'((k / 10) % 2), 1'((k / 15) % 2), 1'((k / 20) % 2)});
      repeat (5) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
